// File: rtl/pipe_mul_sm.sv
// pipe_mul_sm: four-stage pipelined W x W multiplier with valid/ready handshake.
//
// Each operand is reduced to its magnitude, split into two H-bit halves
// (H = W/2), and the product is assembled from four H x H partial products.
// Signed results are produced by negating the unsigned magnitude product.
// The pipeline stalls as a whole whenever the output holds a result that has
// not been consumed.
//
// Ports:
//   clk        - clock, all state updates on the rising edge
//   rst        - synchronous active-high reset
//   a, b       - W-bit operands
//   sgn        - 1 = two's-complement operands, 0 = unsigned
//   in_valid   - operand pair valid
//   in_ready   - block accepts a pair this cycle (combinational)
//   res        - 2W-bit product (registered)
//   out_valid  - res holds a product (registered)
//   out_ready  - downstream consumes res
//   count      - number of products delivered, modulo 2^CW (registered)
module pipe_mul_sm #(
    parameter int W  = 32,
    parameter int CW = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [W-1:0]     a,
    input  logic [W-1:0]     b,
    input  logic             sgn,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [2*W-1:0]   res,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CW-1:0]    count
);

    localparam int H = W / 2;

    // Magnitude of an operand; the most negative value maps onto 2^(W-1),
    // which still fits in W unsigned bits.
    function automatic logic [W-1:0] mag_f(input logic [W-1:0] x, input logic sgn_i);
        logic [W-1:0] m;
        if (sgn_i && x[W-1]) begin
            m = ~x + {{(W-1){1'b0}}, 1'b1};
        end else begin
            m = x;
        end
        return m;
    endfunction

    // Two's-complement negation of a full-width product.
    function automatic logic [2*W-1:0] neg_f(input logic [2*W-1:0] x);
        return ~x + {{(2*W-1){1'b0}}, 1'b1};
    endfunction

    // Unsigned H x H partial product, full 2H-bit result.
    function automatic logic [2*H-1:0] pp_f(input logic [H-1:0] x, input logic [H-1:0] y);
        return {{H{1'b0}}, x} * {{H{1'b0}}, y};
    endfunction

    logic             advance_s;
    logic [W-1:0]     ma_s;
    logic [W-1:0]     mb_s;
    logic             neg_s;
    logic [2*H-1:0]   ll_s;
    logic [2*H-1:0]   lh_s;
    logic [2*H-1:0]   hl_s;
    logic [2*H-1:0]   hh_s;
    logic [2*H:0]     mid_s;
    logic [2*W-1:0]   prod_s;
    logic [2*W-1:0]   res_s;

    logic             s1_v_r;
    logic [W-1:0]     s1_ma_r;
    logic [W-1:0]     s1_mb_r;
    logic             s1_neg_r;
    logic             s2_v_r;
    logic [2*H-1:0]   s2_ll_r;
    logic [2*H-1:0]   s2_lh_r;
    logic [2*H-1:0]   s2_hl_r;
    logic [2*H-1:0]   s2_hh_r;
    logic             s2_neg_r;
    logic             s3_v_r;
    logic [2*H:0]     s3_mid_r;
    logic [2*H-1:0]   s3_ll_r;
    logic [2*H-1:0]   s3_hh_r;
    logic             s3_neg_r;
    logic [2*W-1:0]   res_r;
    logic             out_valid_r;
    logic [CW-1:0]    count_r;

    // The whole pipeline moves when the output slot is empty or being drained.
    assign advance_s = !out_valid_r || out_ready;
    assign in_ready  = advance_s;
    assign res       = res_r;
    assign out_valid = out_valid_r;
    assign count     = count_r;

    // Next-stage datapath values for every pipeline stage.
    always_comb begin
        ma_s   = mag_f(a, sgn);
        mb_s   = mag_f(b, sgn);
        neg_s  = sgn & (a[W-1] ^ b[W-1]);
        ll_s   = pp_f(s1_ma_r[H-1:0], s1_mb_r[H-1:0]);
        lh_s   = pp_f(s1_ma_r[H-1:0], s1_mb_r[W-1:H]);
        hl_s   = pp_f(s1_ma_r[W-1:H], s1_mb_r[H-1:0]);
        hh_s   = pp_f(s1_ma_r[W-1:H], s1_mb_r[W-1:H]);
        mid_s  = {1'b0, s2_lh_r} + {1'b0, s2_hl_r};
        prod_s = {s3_hh_r, {W{1'b0}}}
               + ({{(W-1){1'b0}}, s3_mid_r} << H)
               + {{W{1'b0}}, s3_ll_r};
        if (s3_neg_r) begin
            res_s = neg_f(prod_s);
        end else begin
            res_s = prod_s;
        end
    end

    // Pipeline stage registers; reset clears everything, otherwise a global
    // stall holds every stage including the output.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_v_r      <= 1'b0;
            s1_ma_r     <= {W{1'b0}};
            s1_mb_r     <= {W{1'b0}};
            s1_neg_r    <= 1'b0;
            s2_v_r      <= 1'b0;
            s2_ll_r     <= {(2*H){1'b0}};
            s2_lh_r     <= {(2*H){1'b0}};
            s2_hl_r     <= {(2*H){1'b0}};
            s2_hh_r     <= {(2*H){1'b0}};
            s2_neg_r    <= 1'b0;
            s3_v_r      <= 1'b0;
            s3_mid_r    <= {(2*H+1){1'b0}};
            s3_ll_r     <= {(2*H){1'b0}};
            s3_hh_r     <= {(2*H){1'b0}};
            s3_neg_r    <= 1'b0;
            res_r       <= {(2*W){1'b0}};
            out_valid_r <= 1'b0;
        end else if (advance_s) begin
            s1_v_r      <= in_valid;
            s1_ma_r     <= ma_s;
            s1_mb_r     <= mb_s;
            s1_neg_r    <= neg_s;
            s2_v_r      <= s1_v_r;
            s2_ll_r     <= ll_s;
            s2_lh_r     <= lh_s;
            s2_hl_r     <= hl_s;
            s2_hh_r     <= hh_s;
            s2_neg_r    <= s1_neg_r;
            s3_v_r      <= s2_v_r;
            s3_mid_r    <= mid_s;
            s3_ll_r     <= s2_ll_r;
            s3_hh_r     <= s2_hh_r;
            s3_neg_r    <= s2_neg_r;
            res_r       <= res_s;
            out_valid_r <= s3_v_r;
        end else begin
            s1_v_r      <= s1_v_r;
            out_valid_r <= out_valid_r;
        end
    end

    // Delivered-product counter, wraps naturally at 2^CW.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_r <= {CW{1'b0}};
        end else if (out_valid_r && out_ready) begin
            count_r <= count_r + {{(CW-1){1'b0}}, 1'b1};
        end else begin
            count_r <= count_r;
        end
    end

endmodule

// File: tb/tb_pipe_mul_sm.sv
module tb_pipe_mul_sm;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] a = 32'h0;
    logic [31:0] b = 32'h0;
    logic        sgn = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [63:0] res;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [3:0]  count;

    int checks = 0;
    int failures = 0;
    logic [63:0] exp_q[$];

    pipe_mul_sm #(.W(32), .CW(4)) dut (
        .clk(clk), .rst(rst), .a(a), .b(b), .sgn(sgn),
        .in_valid(in_valid), .in_ready(in_ready),
        .res(res), .out_valid(out_valid), .out_ready(out_ready),
        .count(count)
    );

    always #5 clk = ~clk;

    // Reference product used for the streamed pairs.
    function automatic logic [63:0] ref_mul(input logic [31:0] x, input logic [31:0] y, input logic s);
        logic signed [63:0] sx;
        logic signed [63:0] sy;
        if (s) begin
            sx = {{32{x[31]}}, x};
            sy = {{32{y[31]}}, y};
            return sx * sy;
        end else begin
            return {32'h0, x} * {32'h0, y};
        end
    endfunction

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        checks++; if (res !== 64'h0) begin failures++; $display("FAIL reset_res: got %h expected 0", res); end
        checks++; if (count !== 4'd0) begin failures++; $display("FAIL reset_count: got %0d expected 0", count); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    endtask

    task automatic test_unsigned_max();
        apply_reset();
        for (int cyc = 0; cyc < 6; cyc++) begin
            @(negedge clk);
            out_ready = 1'b1;
            if (cyc == 3) begin
                checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL umax_early: got out_valid %b expected 0", out_valid); end
            end
            if (cyc == 4) begin
                checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL umax_valid: got %b expected 1", out_valid); end
                checks++; if (res !== 64'hFFFFFFFE00000001) begin failures++; $display("FAIL umax_res: got %h expected fffffffe00000001", res); end
            end
            if (cyc == 0) begin
                in_valid = 1'b1; sgn = 1'b0; a = 32'hFFFFFFFF; b = 32'hFFFFFFFF;
            end else begin
                in_valid = 1'b0;
            end
        end
    endtask

    task automatic test_signed_corners();
        logic [31:0] ca[3];
        logic [31:0] cb[3];
        logic [63:0] ce[3];
        ca = '{32'hFFFFFFFF, 32'h80000000, 32'h80000000};
        cb = '{32'hFFFFFFFF, 32'h80000000, 32'h00000001};
        ce = '{64'h0000000000000001, 64'h4000000000000000, 64'hFFFFFFFF80000000};
        apply_reset();
        for (int cyc = 0; cyc < 8; cyc++) begin
            @(negedge clk);
            out_ready = 1'b1;
            if (cyc >= 4 && cyc <= 6) begin
                checks++; if (out_valid !== 1'b1 || res !== ce[cyc-4]) begin
                    failures++; $display("FAIL signed_corner%0d: got v=%b res=%h expected v=1 res=%h", cyc-4, out_valid, res, ce[cyc-4]);
                end
            end
            if (cyc < 3) begin
                in_valid = 1'b1; sgn = 1'b1; a = ca[cyc]; b = cb[cyc];
            end else begin
                in_valid = 1'b0;
            end
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] pa[8];
        logic [31:0] pb[8];
        logic [63:0] held;
        logic [63:0] e;
        logic        stall;
        int sent;
        int got;
        pa = '{32'h12345678, 32'h9ABCDEF0, 32'h0000FFFF, 32'hFFFF0000, 32'h7FFFFFFF, 32'h80000001, 32'h00000007, 32'hC0FFEE11};
        pb = '{32'h87654321, 32'h0FEDCBA9, 32'hFFFF0000, 32'h00010001, 32'h7FFFFFFF, 32'hFFFFFFFE, 32'hFFFFFFF9, 32'h13579BDF};
        apply_reset();
        exp_q.delete();
        sent = 0; got = 0; held = 64'h0;
        for (int cyc = 0; cyc < 40 && got < 8; cyc++) begin
            @(negedge clk);
            stall = (cyc >= 5 && cyc <= 7);
            out_ready = !stall;
            if (cyc == 5) begin
                held = res;
                checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL bp_stall_valid: got %b expected 1", out_valid); end
            end
            if (cyc >= 6 && cyc <= 8) begin
                checks++; if (out_valid !== 1'b1 || res !== held) begin
                    failures++; $display("FAIL bp_hold: got v=%b res=%h expected v=1 res=%h", out_valid, res, held);
                end
            end
            if (out_valid === 1'b1 && out_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++; $display("FAIL bp_extra: got res=%h expected no product", res);
                end else begin
                    e = exp_q.pop_front();
                    if (res !== e) begin failures++; $display("FAIL bp_res%0d: got %h expected %h", got, res, e); end
                end
                got++;
            end
            if (sent < 8) begin
                in_valid = 1'b1; a = pa[sent]; b = pb[sent]; sgn = sent[0];
                if (!stall) begin
                    exp_q.push_back(ref_mul(pa[sent], pb[sent], sent[0]));
                    sent++;
                end
            end else begin
                in_valid = 1'b0;
            end
            #1;
            checks++; if (in_ready !== !stall) begin failures++; $display("FAIL bp_in_ready: cycle %0d got %b expected %b", cyc, in_ready, !stall); end
        end
        checks++; if (got != 8) begin failures++; $display("FAIL bp_timeout: got %0d products expected 8", got); end
        @(negedge clk);
        in_valid = 1'b0;
        checks++; if (count !== 4'd8) begin failures++; $display("FAIL bp_count: got %0d expected 8", count); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL bp_dup: got out_valid %b expected 0", out_valid); end
    endtask

    task automatic test_mixed_bubbles();
        int          pat[8];
        logic [31:0] ma[5];
        logic [31:0] mb[5];
        logic        ms[5];
        logic [63:0] me[5];
        logic        exp_ov;
        int idx;
        int oidx;
        pat = '{1, 0, 1, 1, 0, 0, 1, 1};
        ma = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000000, 32'h80000000, 32'h00001234};
        mb = '{32'h00000002, 32'h00000002, 32'h00000003, 32'h00000003, 32'h00010000};
        ms = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        me = '{64'hFFFFFFFFFFFFFFFE, 64'h00000001FFFFFFFE, 64'hFFFFFFFE80000000, 64'h0000000180000000, 64'h0000000012340000};
        apply_reset();
        idx = 0; oidx = 0;
        for (int cyc = 0; cyc < 14; cyc++) begin
            @(negedge clk);
            out_ready = 1'b1;
            exp_ov = (cyc >= 4 && cyc - 4 < 8) ? (pat[cyc-4] != 0) : 1'b0;
            checks++; if (out_valid !== exp_ov) begin failures++; $display("FAIL mix_valid: cycle %0d got %b expected %b", cyc, out_valid, exp_ov); end
            if (exp_ov && oidx < 5) begin
                checks++; if (res !== me[oidx]) begin failures++; $display("FAIL mix_res%0d: got %h expected %h", oidx, res, me[oidx]); end
                oidx++;
            end
            if (cyc < 8 && pat[cyc] != 0) begin
                in_valid = 1'b1; a = ma[idx]; b = mb[idx]; sgn = ms[idx];
                idx++;
            end else begin
                in_valid = 1'b0; a = 32'hDEADBEEF; b = 32'h0BADF00D; sgn = 1'b1;
            end
        end
    endtask

    task automatic test_reset_midflight();
        for (int cyc = 0; cyc < 13; cyc++) begin
            @(negedge clk);
            out_ready = 1'b1;
            if (cyc == 4) begin
                checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL mid_rst_valid: got %b expected 0", out_valid); end
                checks++; if (res !== 64'h0) begin failures++; $display("FAIL mid_rst_res: got %h expected 0", res); end
                checks++; if (count !== 4'd0) begin failures++; $display("FAIL mid_rst_count: got %0d expected 0", count); end
            end
            if (cyc > 4) begin
                checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL mid_rst_leak: cycle %0d got out_valid %b expected 0", cyc, out_valid); end
            end
            rst = (cyc == 3);
            if (cyc < 3) begin
                in_valid = 1'b1; sgn = 1'b0; a = 32'h00000100 + cyc; b = 32'h00000005;
            end else begin
                in_valid = 1'b0;
            end
        end
        rst = 1'b0;
    endtask

    task automatic test_count_wrap();
        apply_reset();
        for (int cyc = 0; cyc < 23; cyc++) begin
            @(negedge clk);
            out_ready = 1'b1;
            if (cyc == 19) begin
                checks++; if (count !== 4'd15) begin failures++; $display("FAIL wrap_15: got %0d expected 15", count); end
            end
            if (cyc == 20) begin
                checks++; if (count !== 4'd0) begin failures++; $display("FAIL wrap_0: got %0d expected 0", count); end
            end
            if (cyc == 22) begin
                checks++; if (count !== 4'd1) begin failures++; $display("FAIL wrap_17: got %0d expected 1", count); end
            end
            if (cyc < 17) begin
                in_valid = 1'b1; sgn = 1'b0; a = 32'h00000001 + cyc; b = 32'h00000003;
            end else begin
                in_valid = 1'b0;
            end
        end
    endtask

    initial begin
        test_reset();
        test_unsigned_max();
        test_signed_corners();
        test_backpressure();
        test_mixed_bubbles();
        test_reset_midflight();
        test_count_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pipe_mul_sm.md
PIPE_MUL_SM -- requirements
Module: pipe_mul_sm

Interface
REQ-001 SHALL have parameter W, default 32, meaning operand width; legal values are even and at least 4.
REQ-002 SHALL have parameter CW, default 16, meaning width of the delivered-result counter.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port a, input, W bits: multiplicand.
REQ-006 SHALL have port b, input, W bits: multiplier.
REQ-007 SHALL have port sgn, input, 1 bit: 1 = two's-complement operands, 0 = unsigned; sampled with a and b.
REQ-008 SHALL have port in_valid, input, 1 bit: a, b and sgn are valid.
REQ-009 SHALL have port in_ready, output, 1 bit: the block accepts an operand pair this cycle.
REQ-010 SHALL have port res, output, 2W bits: product.
REQ-011 SHALL have port out_valid, output, 1 bit: res holds a product.
REQ-012 SHALL have port out_ready, input, 1 bit: downstream consumes res.
REQ-013 SHALL have port count, output, CW bits: number of products delivered, modulo 2^CW.

Function
REQ-014 SHALL define H = W/2 and split each operand magnitude into a high half and a low half of H bits each.
REQ-015 SHALL define advance = !out_valid || out_ready, and SHALL drive in_ready = advance combinationally.
REQ-016 SHALL accept an operand pair exactly when in_valid && in_ready are both high.
REQ-017 SHALL have 4 register stages (S1-S4); each stage has a valid bit, and all stages shift only when advance is high.
REQ-018 S1 SHALL register |a|, |b| (W-bit unsigned) and neg = sgn & (a[W-1] ^ b[W-1]); when sgn=0, the magnitudes SHALL be the raw operands.
REQ-019 S2 SHALL register the four H x H partial products: LL, LH, HL, HH (each 2H bits), plus neg.
REQ-020 S3 SHALL register mid = LH + HL (2H+1 bits), plus LL, HH and neg.
REQ-021 S4 SHALL register P = (HH << W) + (mid << H) + LL (2W bits), then res = neg ? -P : P, with out_valid = the S3 valid bit.
REQ-022 Latency SHALL be exactly 4 clock edges with advance high from acceptance to out_valid.
REQ-023 Throughput SHALL be one product per cycle while out_ready stays high.
REQ-024 When advance is low, every stage register, including res and out_valid, SHALL hold its value.
REQ-025 Bubbles (stages with valid=0) SHALL NOT be collapsed under stall; the stall is global.
REQ-026 A cycle with in_valid=0 and advance=1 SHALL inject a bubble into S1.
REQ-027 count SHALL increment by 1 on every cycle where out_valid && out_ready, and SHALL wrap from 2^CW-1 to 0.
REQ-028 The signed input -2^(W-1) SHALL be handled exactly: its magnitude 2^(W-1) fits in W unsigned bits.
REQ-029 The result SHALL never overflow 2W bits in either mode.
REQ-030 Data registers of stages with valid=0 are don't-care, but res SHALL only change when advance is high.

Reset
REQ-031 When rst is high at a clock edge, all stage valid bits and out_valid SHALL be cleared, res SHALL be set to 0, and count SHALL be set to 0.
REQ-032 Reset SHALL take priority over advance and in_valid; operands in flight during reset SHALL be discarded and never appear on res.
REQ-033 in_ready SHALL be 1 in the first cycle after reset, because out_valid=0.

Verification (W=32)
REQ-034 Unsigned max: sgn=0, a=b=0xFFFFFFFF accepted, out_ready=1 -> four edges later out_valid=1 and res=0xFFFFFFFE00000001.
REQ-035 Signed corners: sgn=1 pairs (0xFFFFFFFF, 0xFFFFFFFF), (0x80000000, 0x80000000) and (0x80000000, 0x00000001), sent back-to-back -> res=0x1, then 0x4000000000000000, then 0xFFFFFFFF80000000 on consecutive cycles.
REQ-036 Backpressure: stream 8 random pairs with out_ready low for 3 cycles mid-stream -> res and out_valid are held, in_ready=0 during the stall, no product is lost or duplicated, order is preserved, and count=8 at the end.
REQ-037 Mixed mode and bubbles: alternate sgn across pairs, with in_valid gaps -> each res matches its own sgn, and out_valid gaps mirror the input gaps.
REQ-038 Reset mid-flight: assert rst for one cycle with 3 products in flight -> out_valid=0, res=0 and count=0 the next cycle, and none of the 3 products emerge afterwards.
REQ-039 Counter wrap: with CW=4, deliver 17 products -> count=1.
